// File: rtl/risc_ctrl_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : risc_ctrl_fsm_if
// Brief    : Shared memory-port handshake between control FSM and memory.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface risc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/risc_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : risc_ctrl_fsm
// Brief    : Multi-cycle control unit for the 8-bit RISC CPU with memory-wait watchdog.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module risc_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Cen,
  input  logic [7:0]            Ir,
  input  logic                  Zero,
  risc_ctrl_fsm_if.master       bus,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  ir_en,
  output logic                  acc_en,
  output logic                  acc_src,
  output logic [1:0]            alu_op,
  output logic                  halted,
  output logic                  bus_err,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEMRD  = 3'd2,
    MEMWR  = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [2:0] c_op_nop = 3'b000;
  localparam logic [2:0] c_op_lda = 3'b001;
  localparam logic [2:0] c_op_sta = 3'b010;
  localparam logic [2:0] c_op_add = 3'b011;
  localparam logic [2:0] c_op_sub = 3'b100;
  localparam logic [2:0] c_op_jmp = 3'b101;
  localparam logic [2:0] c_op_jz  = 3'b110;

  localparam logic       c_wd_on     = (WAIT_MAX != 0);
  localparam logic [7:0] c_wait_last = 8'(WAIT_MAX - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       w_wait;
  logic       w_run;
  logic [2:0] w_op;
  logic       w_unused_operand;

  assign w_op  = Ir[7:5];
  assign w_run = Cen & ~Rst;
  // Operand bits steer the datapath address mux, not the sequencing.
  assign w_unused_operand = ^Ir[4:0];

  always_comb begin
    w_next = r_state;
    w_wait = 1'b0;
    case (r_state)
      FETCH: begin
        if (bus.mem_ready) w_next = DECODE;
        else               w_wait = 1'b1;
      end
      DECODE: begin
        case (w_op)
          c_op_nop, c_op_jmp, c_op_jz:  w_next = FETCH;
          c_op_lda, c_op_add, c_op_sub: w_next = MEMRD;
          c_op_sta:                     w_next = MEMWR;
          default:                      w_next = HALT;
        endcase
      end
      MEMRD, MEMWR: begin
        if (bus.mem_ready) w_next = FETCH;
        else               w_wait = 1'b1;
      end
      HALT:    w_next = HALT;
      ERR:     w_next = ERR;
      default: w_next = FETCH;
    endcase
    // A late mem_ready on the limit cycle still completes the access.
    if (w_wait && c_wd_on && (r_wait_cnt == c_wait_last)) w_next = ERR;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= FETCH;
      r_wait_cnt <= 8'd0;
    end else if (Cen) begin
      r_state <= w_next;
      if (w_next != r_state) r_wait_cnt <= 8'd0;
      else if (w_wait)       r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    ir_en        = 1'b0;
    acc_en       = 1'b0;
    acc_src      = 1'b0;
    alu_op       = 2'b00;
    if (w_run) begin
      case (r_state)
        FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_en  = 1'b1;
            pc_inc = 1'b1;
          end
        end
        DECODE: begin
          if (w_op == c_op_jmp) pc_load = 1'b1;
          if (w_op == c_op_jz)  pc_load = Zero;
        end
        MEMRD: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          if (bus.mem_ready) begin
            case (w_op)
              c_op_lda: begin acc_en = 1'b1; acc_src = 1'b1; alu_op = 2'b00; end
              c_op_add: begin acc_en = 1'b1; alu_op = 2'b01; end
              c_op_sub: begin acc_en = 1'b1; alu_op = 2'b10; end
              default:  acc_en = 1'b0;
            endcase
          end
        end
        MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = 1'b1;
          bus.addr_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted  = ~Rst & ((r_state == HALT) || (r_state == ERR));
  assign bus_err = ~Rst & (r_state == ERR);
  assign state   = Rst ? 3'd0 : 3'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_risc_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_risc_ctrl_fsm
// Brief    : Scoreboard bench for risc_ctrl_fsm (WAIT_MAX=4).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_risc_ctrl_fsm;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Cen;
  logic [7:0] Ir;
  logic       Zero;
  logic       pc_inc, pc_load, ir_en, acc_en, acc_src, halted, bus_err;
  logic [1:0] alu_op;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  risc_ctrl_fsm_if bus_if ();

  risc_ctrl_fsm #(.WAIT_MAX(4)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Cen     (Cen),
    .Ir      (Ir),
    .Zero    (Zero),
    .bus     (bus_if),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .ir_en   (ir_en),
    .acc_en  (acc_en),
    .acc_src (acc_src),
    .alu_op  (alu_op),
    .halted  (halted),
    .bus_err (bus_err),
    .state   (state)
  );

  always #5 Clk = ~Clk;

  // Packed order: req we asel pinc pld iren accen accsrc op[1:0] hlt berr st[2:0]
  function automatic logic [14:0] ev(input logic req, we, asel, pinc, pld, iren,
                                     accen, accsrc, input logic [1:0] op,
                                     input logic hlt, berr, input logic [2:0] st);
    return {req, we, asel, pinc, pld, iren, accen, accsrc, op, hlt, berr, st};
  endfunction

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  wire [14:0] w_obs = {bus_if.mem_req, bus_if.mem_we, bus_if.addr_sel, pc_inc, pc_load,
                       ir_en, acc_en, acc_src, alu_op, halted, bus_err, state};

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      check_eq(tag_q.pop_front(), w_obs, exp_q.pop_front());
    end
  end

  task automatic step(input string tag, input logic rst, cen, input logic [7:0] ir,
                      input logic zero, rdy, input logic [14:0] exp);
    @(posedge Clk);
    #1;
    Rst = rst; Cen = cen; Ir = ir; Zero = zero; bus_if.mem_ready = rdy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge Clk);
  endtask

  logic [14:0] e_fetch_rdy, e_fetch_wait, e_dec, e_rd_wait, e_wr;
  logic [14:0] e_wr_frozen, e_err, e_halt;

  initial begin
    Rst = 1'b1; Cen = 1'b1; Ir = 8'h21; Zero = 1'b0; bus_if.mem_ready = 1'b1;
    e_fetch_rdy  = ev(1,0,0,1,0,1,0,0,2'b00,0,0,3'd0);
    e_fetch_wait = ev(1,0,0,0,0,0,0,0,2'b00,0,0,3'd0);
    e_dec        = ev(0,0,0,0,0,0,0,0,2'b00,0,0,3'd1);
    e_rd_wait    = ev(1,0,1,0,0,0,0,0,2'b00,0,0,3'd2);
    e_wr         = ev(1,1,1,0,0,0,0,0,2'b00,0,0,3'd3);
    e_wr_frozen  = ev(0,0,0,0,0,0,0,0,2'b00,0,0,3'd3);
    e_err        = ev(0,0,0,0,0,0,0,0,2'b00,1,1,3'd5);
    e_halt       = ev(0,0,0,0,0,0,0,0,2'b00,1,0,3'd4);

    step("reset0", 1, 1, 8'h21, 0, 1, 15'd0);
    step("reset1", 1, 1, 8'h21, 0, 1, 15'd0);
    // LDA 1
    step("lda_fetch", 0, 1, 8'h21, 0, 1, e_fetch_rdy);
    step("lda_dec",   0, 1, 8'h21, 0, 1, e_dec);
    step("lda_mem",   0, 1, 8'h21, 0, 1, ev(1,0,1,0,0,0,1,1,2'b00,0,0,3'd2));
    // ADD 5 with three wait cycles
    step("add_fetch", 0, 1, 8'h65, 0, 1, e_fetch_rdy);
    step("add_dec",   0, 1, 8'h65, 0, 1, e_dec);
    for (int i = 0; i < 3; i++) step("add_wait", 0, 1, 8'h65, 0, 0, e_rd_wait);
    step("add_mem",   0, 1, 8'h65, 0, 1, ev(1,0,1,0,0,0,1,0,2'b01,0,0,3'd2));
    // SUB 5
    step("sub_fetch", 0, 1, 8'h85, 0, 1, e_fetch_rdy);
    step("sub_dec",   0, 1, 8'h85, 0, 1, e_dec);
    step("sub_mem",   0, 1, 8'h85, 0, 1, ev(1,0,1,0,0,0,1,0,2'b10,0,0,3'd2));
    // JZ taken / not taken, JMP
    step("jz1_fetch", 0, 1, 8'hC7, 1, 1, e_fetch_rdy);
    step("jz1_dec",   0, 1, 8'hC7, 1, 1, ev(0,0,0,0,1,0,0,0,2'b00,0,0,3'd1));
    step("jz0_fetch", 0, 1, 8'hC7, 0, 1, e_fetch_rdy);
    step("jz0_dec",   0, 1, 8'hC7, 0, 1, e_dec);
    step("jmp_fetch", 0, 1, 8'hA3, 0, 1, e_fetch_rdy);
    step("jmp_dec",   0, 1, 8'hA3, 0, 1, ev(0,0,0,0,1,0,0,0,2'b00,0,0,3'd1));
    // NOP, then watchdog trips in FETCH after exactly 4 waiting cycles
    step("nop_fetch", 0, 1, 8'h00, 0, 1, e_fetch_rdy);
    step("nop_dec",   0, 1, 8'h00, 0, 1, e_dec);
    for (int i = 0; i < 4; i++) step("wd_wait", 0, 1, 8'h00, 0, 0, e_fetch_wait);
    step("wd_err",      0, 1, 8'h00, 0, 0, e_err);
    step("wd_err_cen0", 0, 0, 8'h00, 0, 1, e_err);
    step("wd_rst",      1, 1, 8'h00, 0, 0, 15'd0);
    // Ready on the limit cycle wins
    for (int i = 0; i < 3; i++) step("wd2_wait", 0, 1, 8'h00, 0, 0, e_fetch_wait);
    step("wd2_ready", 0, 1, 8'h00, 0, 1, e_fetch_rdy);
    step("wd2_dec",   0, 1, 8'h00, 0, 1, e_dec);
    // STA with Cen freeze; counter must hold at 1 across the freeze
    step("sta_fetch", 0, 1, 8'h4A, 0, 1, e_fetch_rdy);
    step("sta_dec",   0, 1, 8'h4A, 0, 1, e_dec);
    step("sta_wait0", 0, 1, 8'h4A, 0, 0, e_wr);
    step("sta_cen0a", 0, 0, 8'h4A, 0, 1, e_wr_frozen);
    step("sta_cen0b", 0, 0, 8'h4A, 0, 0, e_wr_frozen);
    step("sta_wait1", 0, 1, 8'h4A, 0, 0, e_wr);
    step("sta_wait2", 0, 1, 8'h4A, 0, 0, e_wr);
    step("sta_done",  0, 1, 8'h4A, 0, 1, e_wr);
    // HLT
    step("hlt_fetch", 0, 1, 8'hE0, 0, 1, e_fetch_rdy);
    step("hlt_dec",   0, 1, 8'hE0, 0, 1, e_dec);
    for (int i = 0; i < 3; i++) step("hlt_hold", 0, 1, 8'hE0, 0, 1, e_halt);
    step("hlt_rst",   1, 1, 8'hE0, 0, 1, 15'd0);
    // Reset in the middle of a write
    step("sta2_fetch", 0, 1, 8'h4A, 0, 1, e_fetch_rdy);
    step("sta2_dec",   0, 1, 8'h4A, 0, 1, e_dec);
    step("sta2_wait",  0, 1, 8'h4A, 0, 0, e_wr);
    step("sta2_rst",   1, 1, 8'h4A, 0, 0, 15'd0);
    step("sta2_after", 0, 1, 8'h4A, 0, 0, e_fetch_wait);

    @(posedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_ctrl_fsm.md
Name: risc_ctrl_fsm

Overview:
Multi-cycle control unit for the 8-bit RISC CPU. It sequences the Reg8-based datapath registers (PC, IR, ACC) and the shared memory port: it fetches, decodes 3-bit opcodes, issues memory read/write handshakes and pulses the register enables. It sits between the instruction register output and the PC/IR/ACC enable inputs. It also provides a memory-wait watchdog.

Parameters:
WAIT_MAX, 15, maximum consecutive cycles mem_req may wait for mem_ready before the bus error trips (0 disables the watchdog; legal range 0..255)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  reset, synchronous, active-high
Cen  input  1  clock enable; when 0 the FSM freezes
Ir  input  8  current instruction (IR register OutD); [7:5] opcode, [4:0] operand address
Zero  input  1  accumulator-zero flag
mem_ready  input  1  memory handshake completion; sampled only while mem_req=1
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  write qualifier for mem_req
addr_sel  output  1  address mux: 0 = PC, 1 = Ir[4:0]
pc_inc  output  1  PC increment strobe
pc_load  output  1  PC load-from-Ir[4:0] strobe
ir_en  output  1  IR load strobe
acc_en  output  1  ACC load strobe
acc_src  output  1  ACC input mux: 0 = ALU, 1 = memory data
alu_op  output  2  00 pass, 01 add, 10 sub, 11 unused
halted  output  1  CPU stopped (HLT or bus error)
bus_err  output  1  watchdog tripped
state  output  3  current state, for debug

Behaviour:
- State register: FETCH=0, DECODE=1, MEMRD=2, MEMWR=3, HALT=4, ERR=5. States 6/7 go to FETCH.
- Outputs are combinational from state, Ir, Zero and mem_ready (Mealy strobes). State and the wait counter are registered.
- Reset: on any Clk edge with Rst=1, state goes to FETCH and the counter is cleared. While Rst=1, all outputs are 0 and state reads 0. Rst overrides Cen. Rst mid-access drops mem_req/mem_we immediately.
- Cen=0: state and counter hold; mem_ready is ignored. All outputs are 0 except halted, bus_err and state.
- FETCH: mem_req=1, addr_sel=0. When mem_ready=1, ir_en=1 and pc_inc=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE (one cycle, decodes Ir[7:5]):
  - 000 NOP: go to FETCH.
  - 001 LDA, 011 ADD, 100 SUB: go to MEMRD.
  - 010 STA: go to MEMWR.
  - 101 JMP: pc_load=1, go to FETCH.
  - 110 JZ: pc_load=Zero, go to FETCH.
  - 111 HLT: go to HALT.
- MEMRD: mem_req=1, addr_sel=1. When mem_ready=1: acc_en=1, with acc_src=1 and alu_op=00 for LDA, or acc_src=0 and alu_op=01 for ADD / 10 for SUB. Then go to FETCH.
- MEMWR: mem_req=1, mem_we=1, addr_sel=1. When mem_ready=1, go to FETCH.
- HALT: halted=1, all strobes 0. Exited only by Rst.
- ERR: halted=1, bus_err=1, all strobes 0. Exited only by Rst.
- Ir is assumed stable from DECODE until the instruction completes; the FSM does not latch it.
- Watchdog (8-bit counter):
  - Cleared on every state transition.
  - In FETCH/MEMRD/MEMWR with Cen=1 and mem_ready=0, it increments.
  - If WAIT_MAX≠0, the counter equals WAIT_MAX-1 and mem_ready=0, the next state is ERR. So mem_req is asserted at most WAIT_MAX cycles without response.
  - mem_ready=1 in the same cycle the limit is reached wins; the access completes normally.
- Minimum latencies (mem_ready tied 1): NOP/JMP/JZ 2 cycles; LDA/ADD/SUB/STA 3 cycles.
- Strobes are single-cycle. pc_inc and pc_load are never asserted together.

Test Plan:
- Rst 2 cycles, Ir=0x21 (LDA 1), mem_ready=1 -> cycle 1: ir_en=pc_inc=1, addr_sel=0; cycle 2: state=1; cycle 3: acc_en=1, acc_src=1, alu_op=00, addr_sel=1; cycle 4: state=0.
- Ir=0x65 (ADD 5), mem_ready delayed 3 cycles in MEMRD -> mem_req=1 and addr_sel=1 for 4 cycles; acc_en=1, alu_op=01 only in the 4th; then FETCH.
- Ir=0xC7 (JZ) with Zero=1 -> pc_load=1 for one cycle in DECODE. With Zero=0 -> pc_load=0. Both return to FETCH after 2 cycles. Ir=0xA3 (JMP) -> pc_load=1.
- WAIT_MAX=4, mem_ready held 0 in FETCH -> mem_req=1 for exactly 4 cycles, then state=5, bus_err=1, halted=1, mem_req=0. Rst=1 -> FETCH. Repeat with mem_ready=1 on the 4th cycle -> no error.
- In MEMWR (Ir=0x4A), drop Cen for 2 cycles while mem_ready=1 -> mem_req=mem_we=0, state stays 3, counter frozen. Cen=1 with mem_ready=1 -> completes, then FETCH.
- Ir=0xE0 (HLT) -> state=4, halted=1 indefinitely, no mem_req. Assert Rst mid-MEMWR of a later run -> mem_we drops in the same cycle, state=0 next edge.
